// File: rtl/rx_line_conditioner.sv
// rx_line_conditioner: synchronise, deglitch and monitor the raw UART Rx pin for break, idle and start edges
module rx_line_conditioner #(
  parameter int EDGE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Rx_i,
  input  logic                  p_BaudSig_i,
  input  logic [3:0]            FilterLen_i,
  input  logic [7:0]            BreakBits_i,
  input  logic [7:0]            IdleBits_i,
  input  logic                  n_EdgeClr_i,
  output logic                  Rx_o,
  output logic                  p_Break_o,
  output logic                  p_BreakStart_o,
  output logic                  p_Idle_o,
  output logic                  p_IdleStart_o,
  output logic [EDGE_CNT_W-1:0] EdgeCnt_o
);
  typedef enum logic {IDLE_CNT, ASSERTED} det_t;
  logic       s1, s2, rx_d;
  logic [3:0] fcnt;
  logic [7:0] bcnt, icnt;
  det_t       brk_q, brk_d, idl_q, idl_d;
  // two-flop synchroniser followed by a run-length deglitch filter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      Rx_o <= 1'b1;
      fcnt <= '0;
    end else begin
      s1 <= Rx_i;
      s2 <= s1;
      if (s2 == Rx_o) fcnt <= '0;
      else if (fcnt >= FilterLen_i) begin
        Rx_o <= s2;
        fcnt <= '0;
      end else fcnt <= fcnt + 4'd1;
    end
  // bit-time counters: low time for break, high time for idle, saturating
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bcnt <= '0;
      icnt <= '0;
    end else begin
      bcnt <= Rx_o ? 8'd0 : (p_BaudSig_i && bcnt != 8'hFF) ? bcnt + 8'd1 : bcnt;
      icnt <= !Rx_o ? 8'd0 : (p_BaudSig_i && icnt != 8'hFF) ? icnt + 8'd1 : icnt;
    end
  // detector next state: enter on threshold, leave on opposite level or disabled threshold
  always_comb begin
    brk_d = brk_q;
    idl_d = idl_q;
    brk_d = (brk_q == IDLE_CNT)
          ? ((|BreakBits_i && !Rx_o && bcnt >= BreakBits_i) ? ASSERTED : IDLE_CNT)
          : ((Rx_o || !(|BreakBits_i)) ? IDLE_CNT : ASSERTED);
    idl_d = (idl_q == IDLE_CNT)
          ? ((|IdleBits_i && Rx_o && icnt >= IdleBits_i) ? ASSERTED : IDLE_CNT)
          : ((!Rx_o || !(|IdleBits_i)) ? IDLE_CNT : ASSERTED);
  end
  // detector state registers; start pulses mark only the entry into ASSERTED
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      brk_q          <= IDLE_CNT;
      idl_q          <= IDLE_CNT;
      p_BreakStart_o <= 1'b0;
      p_IdleStart_o  <= 1'b0;
    end else begin
      brk_q          <= brk_d;
      idl_q          <= idl_d;
      p_BreakStart_o <= (brk_q == IDLE_CNT) && (brk_d == ASSERTED);
      p_IdleStart_o  <= (idl_q == IDLE_CNT) && (idl_d == ASSERTED);
    end
  assign p_Break_o = (brk_q == ASSERTED);
  assign p_Idle_o  = (idl_q == ASSERTED);
  // falling-edge counter on the conditioned line; clear beats increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_d      <= 1'b1;
      EdgeCnt_o <= '0;
    end else begin
      rx_d <= Rx_o;
      if (!n_EdgeClr_i) EdgeCnt_o <= '0;
      else if (rx_d && !Rx_o && !(&EdgeCnt_o)) EdgeCnt_o <= EdgeCnt_o + 1'b1;
    end
endmodule
